game_round_ctrl: RTL
====================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter TOTAL_PILLS, default 244: pills on the board; legal range 1..511.
REQ-002 Parameter DEATH_CYCLES, default 50_000_000: DYING freeze length in clocks.
REQ-003 Parameter CLEAR_CYCLES, default 100_000_000: CLEAR freeze length in clocks.
REQ-004 Parameter POWER_CYCLES, default 300_000_000: power-pill window length in clocks.
REQ-005 CLOCK_50  in  1: single system clock; all state updates on posedge.
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 start  in  1: level-sensitive start request from a player button.
REQ-008 collision_type  in  4: pacman collision code; 4'b0010 pill, 4'b0011 power pill, 4'b0100 ghost, other values none.
REQ-009 pill_count  out  9: pills eaten this board, unsigned binary.
REQ-010 lives  out  2: remaining lives.
REQ-011 freeze  out  1: high while movement is halted (IDLE, DYING, CLEAR, OVER).
REQ-012 board_reset  out  1: one-cycle pulse commanding a board and sprite reload.
REQ-013 power_active  out  1: high while the power window runs.
REQ-014 ghost_eaten  out  1: one-cycle pulse when a ghost is eaten during power.
REQ-015 game_over  out  1: high in OVER.

Function
REQ-016 States SHALL be IDLE, PLAY, DYING, CLEAR, OVER; all outputs registered.
REQ-017 Event detection: an event fires on the first cycle collision_type takes a code differing from the previous cycle's sampled value; a held code fires once.
REQ-018 IDLE: start high -> PLAY next cycle; board_reset pulses on that transition; lives=3, pill_count=0.
REQ-019 PLAY pill event: pill_count +1 on the following clock edge.
REQ-020 PLAY power-pill event: pill_count +1; power timer loads POWER_CYCLES; power_active high; a repeat power pill reloads the timer.
REQ-021 Power timer decrements each PLAY cycle; power_active drops on the cycle it reaches 0; timer holds (no decrement) outside PLAY.
REQ-022 PLAY ghost event with power_active: ghost_eaten pulses one cycle, no state change.
REQ-023 PLAY ghost event without power_active: -> DYING; lives decrements by 1.
REQ-024 Board clear: when a pill or power-pill event makes pill_count equal TOTAL_PILLS, -> CLEAR the same edge; the count never exceeds TOTAL_PILLS.
REQ-025 DYING: freeze high for DEATH_CYCLES clocks; then lives==0 -> OVER, else -> PLAY with board_reset pulse; pill_count retained; power cleared.
REQ-026 CLEAR: freeze high for CLEAR_CYCLES clocks; then -> PLAY with board_reset pulse, pill_count=0, power cleared, lives retained.
REQ-027 OVER: game_over high, all counts frozen; start high -> IDLE next cycle.
REQ-028 Events outside PLAY SHALL be ignored, including an edge arriving on the exit edge from DYING/CLEAR; the edge detector keeps tracking.
REQ-029 Ghost event and clearing pill cannot coincide (one code per cycle); clear takes priority over a power-timer expiry on the same edge.
REQ-030 lives SHALL never wrap below 0; counters sized by $clog2 of their parameter.

Reset
REQ-031 reset high SHALL, on the next edge, force IDLE, pill_count=0, lives=3, freeze=1, board_reset=0, power_active=0, ghost_eaten=0, game_over=0, timers=0, previous-code register=4'b0000.
REQ-032 reset SHALL override every state, including mid-DYING/CLEAR countdown, and take priority over start.

Verification (TOTAL_PILLS=3, DEATH_CYCLES=4, CLEAR_CYCLES=4, POWER_CYCLES=6)
REQ-033 Reset, start 1 cycle -> PLAY, board_reset single pulse, lives=3, freeze=0.
REQ-034 Pill code held 5 cycles, then 0000, then pill again -> pill_count 1 then 2.
REQ-035 Third pill -> CLEAR, freeze 4 cycles, board_reset pulse, pill_count=0, back in PLAY.
REQ-036 Power pill then ghost within 6 cycles -> ghost_eaten single pulse, lives=3; ghost after expiry -> DYING, lives=2.
REQ-037 Three unpowered ghost deaths -> lives 2,1,0, then OVER with game_over=1; start -> IDLE.
REQ-038 reset asserted mid-DYING countdown -> IDLE next edge with all REQ-031 values.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Round sequencer for a maze game: tracks pills, lives and the power window,
// and freezes play for death and board-clear pauses.
module game_round_ctrl #(
  parameter int TOTAL_PILLS  = 244,
  parameter int DEATH_CYCLES = 50_000_000,
  parameter int CLEAR_CYCLES = 100_000_000,
  parameter int POWER_CYCLES = 300_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] collision_type,
  output logic [8:0] pill_count,
  output logic [1:0] lives,
  output logic       freeze,
  output logic       board_reset,
  output logic       power_active,
  output logic       ghost_eaten,
  output logic       game_over
);

  localparam int HOLD_MAX = (DEATH_CYCLES > CLEAR_CYCLES) ? DEATH_CYCLES : CLEAR_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int POWER_W  = (POWER_CYCLES > 1) ? $clog2(POWER_CYCLES + 1) : 1;

  // Index 0 = pill, 1 = power pill, 2 = ghost.
  localparam logic [2:0][3:0] EVENT_CODE = {4'b0100, 4'b0011, 4'b0010};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    DYING = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state_reg;
  logic [3:0]         prev_code_reg;
  logic [8:0]         pill_count_reg;
  logic [1:0]         lives_reg;
  logic               freeze_reg;
  logic               board_reset_reg;
  logic               power_active_reg;
  logic               ghost_eaten_reg;
  logic               game_over_reg;
  logic [POWER_W-1:0] power_timer_reg;
  logic [HOLD_W-1:0]  hold_timer_reg;

  logic               code_changed;
  logic [2:0]         code_hit;
  logic               pill_ev;
  logic               power_ev;
  logic               ghost_ev;
  logic [8:0]         pill_count_next;
  logic               board_full;
  logic [POWER_W-1:0] power_timer_next;

  // A held code fires once: only a change against last cycle's sample counts.
  assign code_changed = (collision_type != prev_code_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_event
      assign code_hit[gi] = code_changed && (collision_type == EVENT_CODE[gi]);
    end
  endgenerate

  assign pill_ev         = code_hit[0];
  assign power_ev        = code_hit[1];
  assign ghost_ev        = code_hit[2];
  assign pill_count_next = pill_count_reg + 9'd1;
  assign board_full      = (pill_ev || power_ev) && (pill_count_next == 9'(TOTAL_PILLS));

  always_comb begin
    power_timer_next = power_timer_reg;
    if (power_ev) begin
      power_timer_next = POWER_W'(POWER_CYCLES);
    end else if (power_timer_reg != '0) begin
      power_timer_next = power_timer_reg - POWER_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg        <= IDLE;
      prev_code_reg    <= 4'b0000;
      pill_count_reg   <= 9'd0;
      lives_reg        <= 2'd3;
      freeze_reg       <= 1'b1;
      board_reset_reg  <= 1'b0;
      power_active_reg <= 1'b0;
      ghost_eaten_reg  <= 1'b0;
      game_over_reg    <= 1'b0;
      power_timer_reg  <= '0;
      hold_timer_reg   <= '0;
    end else begin
      prev_code_reg   <= collision_type;
      board_reset_reg <= 1'b0;
      ghost_eaten_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg       <= PLAY;
            board_reset_reg <= 1'b1;
            lives_reg       <= 2'd3;
            pill_count_reg  <= 9'd0;
            freeze_reg      <= 1'b0;
          end
        end

        PLAY: begin
          power_timer_reg  <= power_timer_next;
          power_active_reg <= (power_timer_next != '0);
          if (pill_ev || power_ev) begin
            pill_count_reg <= pill_count_next;
            if (board_full) begin
              state_reg      <= CLEAR;
              hold_timer_reg <= HOLD_W'(CLEAR_CYCLES - 1);
              freeze_reg     <= 1'b1;
            end
          end else if (ghost_ev) begin
            if (power_active_reg) begin
              ghost_eaten_reg <= 1'b1;
            end else begin
              state_reg      <= DYING;
              hold_timer_reg <= HOLD_W'(DEATH_CYCLES - 1);
              freeze_reg     <= 1'b1;
              if (lives_reg != 2'd0) begin
                lives_reg <= lives_reg - 2'd1;
              end
            end
          end
        end

        DYING: begin
          if (hold_timer_reg == '0) begin
            if (lives_reg == 2'd0) begin
              state_reg     <= OVER;
              game_over_reg <= 1'b1;
            end else begin
              state_reg        <= PLAY;
              freeze_reg       <= 1'b0;
              board_reset_reg  <= 1'b1;
              power_timer_reg  <= '0;
              power_active_reg <= 1'b0;
            end
          end else begin
            hold_timer_reg <= hold_timer_reg - HOLD_W'(1);
          end
        end

        CLEAR: begin
          if (hold_timer_reg == '0) begin
            state_reg        <= PLAY;
            freeze_reg       <= 1'b0;
            board_reset_reg  <= 1'b1;
            pill_count_reg   <= 9'd0;
            power_timer_reg  <= '0;
            power_active_reg <= 1'b0;
          end else begin
            hold_timer_reg <= hold_timer_reg - HOLD_W'(1);
          end
        end

        OVER: begin
          if (start) begin
            state_reg     <= IDLE;
            game_over_reg <= 1'b0;
          end
        end

        default: begin
          state_reg  <= IDLE;
          freeze_reg <= 1'b1;
        end
      endcase
    end
  end

  assign pill_count   = pill_count_reg;
  assign lives        = lives_reg;
  assign freeze       = freeze_reg;
  assign board_reset  = board_reset_reg;
  assign power_active = power_active_reg;
  assign ghost_eaten  = ghost_eaten_reg;
  assign game_over    = game_over_reg;

endmodule
